// File: rtl/wb_commit_stage.sv
// ---------------------------------------------------------------------------
// WbCommitStage (module wb_commit_stage)
//
// Write-back / commit stage of the in-order pipeline. It holds one
// instruction from the memory stage. Once the CSR file is ready, the stage
// commits that instruction: it raises an exception or ERTN redirect, or it
// issues the register-file and CSR writes. It also counts retired
// instructions.
//
// Ports
//   clk, reset            clock and synchronous active-high reset
//   ms_to_ws_valid        memory stage offers an instruction
//   ws_allowin            this stage can take an instruction this cycle
//   ms_pc/result/badv     instruction PC, result, faulting data address
//   ms_gr_we, ms_dest     GPR write enable and destination register
//   ms_exc_vec            synchronous exception flags (bit 0 highest)
//   ms_ertn, ms_csr_*     ERTN flag and CSR access fields
//   int_pending           qualified interrupt from the CSR file
//   csr_busy              CSR file not ready; holds the stage
//   csr_rvalue/eentry/era CSR read data, exception entry, return address
//   csr_re/we/num/...     CSR access issued to the CSR file
//   wb_ex/ertn/ecode/...  exception and ERTN report to the CSR file
//   flush_pc              redirect target for the front end
//   rf_bus                {ws_valid, rf_we, rf_waddr, rf_wdata}
//   retire_cnt            number of committed instructions
//   debug_wb_*            trace port that mirrors the register-file write
// ---------------------------------------------------------------------------
module wb_commit_stage #(
    parameter int                   DATA_W      = 32,
    parameter int                   NUM_EXC     = 5,
    parameter logic [6*NUM_EXC-1:0] ECODE_TABLE = {6'h9, 6'hC, 6'hB, 6'hD, 6'h8},
    parameter int                   CNT_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ms_to_ws_valid,
    output logic                ws_allowin,
    input  logic [DATA_W-1:0]   ms_pc,
    input  logic [DATA_W-1:0]   ms_result,
    input  logic [DATA_W-1:0]   ms_badv,
    input  logic                ms_gr_we,
    input  logic [4:0]          ms_dest,
    input  logic [NUM_EXC-1:0]  ms_exc_vec,
    input  logic                ms_ertn,
    input  logic                ms_csr_re,
    input  logic                ms_csr_we,
    input  logic [13:0]         ms_csr_num,
    input  logic [DATA_W-1:0]   ms_csr_wmask,
    input  logic [DATA_W-1:0]   ms_csr_wvalue,
    input  logic                int_pending,
    input  logic                csr_busy,
    input  logic [DATA_W-1:0]   csr_rvalue,
    input  logic [DATA_W-1:0]   csr_eentry,
    input  logic [DATA_W-1:0]   csr_era,
    output logic                csr_re,
    output logic                csr_we,
    output logic [13:0]         csr_num,
    output logic [DATA_W-1:0]   csr_wmask,
    output logic [DATA_W-1:0]   csr_wvalue,
    output logic                wb_ex,
    output logic                wb_ertn,
    output logic [5:0]          wb_ecode,
    output logic [8:0]          wb_esubcode,
    output logic [DATA_W-1:0]   wb_pc,
    output logic [DATA_W-1:0]   wb_vaddr,
    output logic [DATA_W-1:0]   flush_pc,
    output logic [DATA_W+6:0]   rf_bus,
    output logic [CNT_W-1:0]    retire_cnt,
    output logic [DATA_W-1:0]   debug_wb_pc,
    output logic [3:0]          debug_wb_rf_we,
    output logic [4:0]          debug_wb_rf_wnum,
    output logic [DATA_W-1:0]   debug_wb_rf_wdata
);

    logic                wsValid_q;
    logic                wsValid_d;
    logic [DATA_W-1:0]   pc_q;
    logic [DATA_W-1:0]   result_q;
    logic [DATA_W-1:0]   badv_q;
    logic                grWe_q;
    logic [4:0]          dest_q;
    logic [NUM_EXC-1:0]  excVec_q;
    logic                ertn_q;
    logic                csrRe_q;
    logic                csrWe_q;
    logic [13:0]         csrNum_q;
    logic [DATA_W-1:0]   csrWmask_q;
    logic [DATA_W-1:0]   csrWvalue_q;
    logic [CNT_W-1:0]    retireCnt_q;
    logic [CNT_W-1:0]    retireCnt_d;

    logic                wsValid;
    logic                commit;
    logic                excPending;
    logic [NUM_EXC-1:0]  excLowest;
    logic [5:0]          excEcode;
    logic                rfWe;
    logic [DATA_W-1:0]   rfWdata;

    // A synchronous reset would otherwise let a stale valid bit drive side
    // effects for the whole reset cycle. This gated valid keeps every output
    // quiet while reset is high.
    assign wsValid    = wsValid_q && !reset;
    assign ws_allowin = !wsValid || !csr_busy;
    assign commit     = wsValid && !csr_busy;

    // The interrupt is sampled live because the CSR file qualifies it.
    // Two's-complement masking isolates the lowest set flag, which is the
    // highest-priority synchronous exception.
    assign excPending = int_pending || (|excVec_q);
    assign excLowest  = excVec_q & (~excVec_q + NUM_EXC'(1));

    // Look up the ecode of the winning synchronous source. Only one bit of
    // excLowest can be set, so the loop acts as a one-hot mux.
    always_comb begin
        excEcode = 6'h0;
        for (int i = 0; i < NUM_EXC; i++) begin
            if (excLowest[i]) begin
                excEcode = ECODE_TABLE[6*i +: 6];
            end
        end
    end

    assign wb_ex       = commit && excPending;
    assign wb_ertn     = commit && ertn_q && !wb_ex;
    assign wb_ecode    = (wb_ex && !int_pending) ? excEcode : 6'h0;
    assign wb_esubcode = 9'h0;
    assign wb_pc       = pc_q;

    // Instruction-fetch faults report the PC, and misaligned accesses report
    // the data address. The other causes carry no address.
    always_comb begin
        wb_vaddr = '0;
        if (wb_ex && !int_pending) begin
            if (excLowest[0]) begin
                wb_vaddr = pc_q;
            end else if (excLowest[NUM_EXC-1]) begin
                wb_vaddr = badv_q;
            end
        end
    end

    assign flush_pc = wb_ex ? csr_eentry : (wb_ertn ? csr_era : '0);

    // ERTN reads ERA through the normal CSR read port. The read request
    // stays up while the stage stalls, so the data is ready at commit.
    assign csr_num    = ertn_q ? 14'h6 : csrNum_q;
    assign csr_re     = wsValid && (csrRe_q || ertn_q);
    assign csr_we     = commit && csrWe_q && !wb_ex;
    assign csr_wmask  = csrWmask_q;
    assign csr_wvalue = csrWvalue_q;

    assign rfWe    = commit && grWe_q && !wb_ex;
    assign rfWdata = csrRe_q ? csr_rvalue : result_q;
    assign rf_bus  = {wsValid, rfWe, dest_q, rfWdata};

    assign debug_wb_pc       = pc_q;
    assign debug_wb_rf_we    = {4{rfWe}};
    assign debug_wb_rf_wnum  = dest_q;
    assign debug_wb_rf_wdata = rfWdata;
    assign retire_cnt        = retireCnt_q;

    // Next-state logic for the valid bit and the retire counter. A redirect
    // empties the stage and drops whatever the memory stage offers in that
    // cycle, because that instruction is on the wrong path.
    always_comb begin
        wsValid_d = wsValid_q;
        if (wb_ex || wb_ertn) begin
            wsValid_d = 1'b0;
        end else if (ws_allowin) begin
            wsValid_d = ms_to_ws_valid;
        end
        retireCnt_d = retireCnt_q;
        if (commit && !wb_ex) begin
            retireCnt_d = retireCnt_q + CNT_W'(1);
        end
    end

    // State registers. The payload loads only on a handshake and holds
    // through stalls. Reset clears everything so that no stale instruction
    // can commit afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            wsValid_q   <= 1'b0;
            retireCnt_q <= '0;
            pc_q        <= '0;
            result_q    <= '0;
            badv_q      <= '0;
            grWe_q      <= 1'b0;
            dest_q      <= '0;
            excVec_q    <= '0;
            ertn_q      <= 1'b0;
            csrRe_q     <= 1'b0;
            csrWe_q     <= 1'b0;
            csrNum_q    <= '0;
            csrWmask_q  <= '0;
            csrWvalue_q <= '0;
        end else begin
            wsValid_q   <= wsValid_d;
            retireCnt_q <= retireCnt_d;
            if (ms_to_ws_valid && ws_allowin) begin
                pc_q        <= ms_pc;
                result_q    <= ms_result;
                badv_q      <= ms_badv;
                grWe_q      <= ms_gr_we;
                dest_q      <= ms_dest;
                excVec_q    <= ms_exc_vec;
                ertn_q      <= ms_ertn;
                csrRe_q     <= ms_csr_re;
                csrWe_q     <= ms_csr_we;
                csrNum_q    <= ms_csr_num;
                csrWmask_q  <= ms_csr_wmask;
                csrWvalue_q <= ms_csr_wvalue;
            end
        end
    end

endmodule

// File: tb/tb_wb_commit_stage.sv
// ---------------------------------------------------------------------------
// Testbench for wb_commit_stage. A transaction-level reference model holds
// the single instruction the stage owns and predicts every visible output
// from the commit rules. Directed scenarios come first, followed by a
// randomized run.
// ---------------------------------------------------------------------------
module tb_wb_commit_stage;

    localparam int DATA_W  = 32;
    localparam int NUM_EXC = 5;
    localparam int CNT_W   = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              ms_to_ws_valid;
    logic              ws_allowin;
    logic [31:0]       ms_pc, ms_result, ms_badv;
    logic              ms_gr_we;
    logic [4:0]        ms_dest;
    logic [4:0]        ms_exc_vec;
    logic              ms_ertn, ms_csr_re, ms_csr_we;
    logic [13:0]       ms_csr_num;
    logic [31:0]       ms_csr_wmask, ms_csr_wvalue;
    logic              int_pending, csr_busy;
    logic [31:0]       csr_rvalue, csr_eentry, csr_era;
    logic              csr_re, csr_we;
    logic [13:0]       csr_num;
    logic [31:0]       csr_wmask, csr_wvalue;
    logic              wb_ex, wb_ertn;
    logic [5:0]        wb_ecode;
    logic [8:0]        wb_esubcode;
    logic [31:0]       wb_pc, wb_vaddr, flush_pc;
    logic [38:0]       rf_bus;
    logic [31:0]       retire_cnt;
    logic [31:0]       debug_wb_pc;
    logic [3:0]        debug_wb_rf_we;
    logic [4:0]        debug_wb_rf_wnum;
    logic [31:0]       debug_wb_rf_wdata;

    int checkCount = 0;
    int errorCount = 0;

    // Architectural ecodes per exception bit: ADEF, INE, SYS, BRK, ALE.
    int ecodeTab[5] = '{8, 'hD, 'hB, 'hC, 9};

    // The reference model is the one instruction the stage owns, plus the
    // retire count.
    logic        mValid;
    logic [31:0] mPc, mResult, mBadv, mMask, mWval;
    logic        mGrWe, mErtn, mCsrRe, mCsrWe;
    logic [4:0]  mDest, mExc;
    logic [13:0] mCsrNum;
    logic [31:0] mCnt;

    // The model's predictions for the current cycle. The clock-advance
    // task reuses them.
    logic expAllowin, expCommit, expEx, expErtn;

    wb_commit_stage #(
        .DATA_W(DATA_W), .NUM_EXC(NUM_EXC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_result(ms_result), .ms_badv(ms_badv),
        .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_exc_vec(ms_exc_vec),
        .ms_ertn(ms_ertn), .ms_csr_re(ms_csr_re), .ms_csr_we(ms_csr_we),
        .ms_csr_num(ms_csr_num), .ms_csr_wmask(ms_csr_wmask),
        .ms_csr_wvalue(ms_csr_wvalue),
        .int_pending(int_pending), .csr_busy(csr_busy),
        .csr_rvalue(csr_rvalue), .csr_eentry(csr_eentry), .csr_era(csr_era),
        .csr_re(csr_re), .csr_we(csr_we), .csr_num(csr_num),
        .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .wb_ex(wb_ex), .wb_ertn(wb_ertn), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
        .flush_pc(flush_pc), .rf_bus(rf_bus), .retire_cnt(retire_cnt),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value differs
    // from the expected value.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive an idle memory stage and a ready CSR file.
    task automatic idleInputs();
        reset = 1'b0; ms_to_ws_valid = 1'b0; ms_pc = '0; ms_result = '0;
        ms_badv = '0; ms_gr_we = 1'b0; ms_dest = '0; ms_exc_vec = '0;
        ms_ertn = 1'b0; ms_csr_re = 1'b0; ms_csr_we = 1'b0; ms_csr_num = '0;
        ms_csr_wmask = '0; ms_csr_wvalue = '0; int_pending = 1'b0;
        csr_busy = 1'b0;
    endtask

    // Offer a plain instruction with the given PC, destination and result.
    task automatic offerInstr(input logic [31:0] pc, input logic [4:0] dest,
                              input logic [31:0] res);
        ms_to_ws_valid = 1'b1; ms_pc = pc; ms_dest = dest; ms_result = res;
        ms_gr_we = 1'b1; ms_exc_vec = '0; ms_ertn = 1'b0;
        ms_csr_re = 1'b0; ms_csr_we = 1'b0;
    endtask

    // Inputs are already driven for this cycle. Let them settle, predict
    // every output from the model, and compare.
    task automatic applyStimulus();
        logic        vld;
        logic        rfWe;
        logic [31:0] wdata, flush;
        int          idx;
        logic [5:0]  ecode;
        logic [31:0] vaddr;
        #1;
        vld        = mValid && !reset;
        expAllowin = !vld || !csr_busy;
        expCommit  = vld && !csr_busy;
        expEx      = expCommit && (int_pending || (mExc != 0));
        expErtn    = expCommit && mErtn && !expEx;
        idx = -1;
        for (int i = 0; i < 5; i++) begin
            if (mExc[i] && idx < 0) idx = i;
        end
        ecode = 6'h0;
        vaddr = 32'h0;
        if (!int_pending && idx >= 0) begin
            ecode = 6'(ecodeTab[idx]);
            if (idx == 0) vaddr = mPc;
            else if (idx == 4) vaddr = mBadv;
        end
        flush = expEx ? csr_eentry : (expErtn ? csr_era : 32'h0);
        rfWe  = expCommit && mGrWe && !expEx;
        wdata = mCsrRe ? csr_rvalue : mResult;
        checkOutput("ws_allowin", 64'(ws_allowin), 64'(expAllowin));
        checkOutput("wb_ex", 64'(wb_ex), 64'(expEx));
        checkOutput("wb_ertn", 64'(wb_ertn), 64'(expErtn));
        checkOutput("flush_pc", 64'(flush_pc), 64'(flush));
        checkOutput("csr_re", 64'(csr_re), 64'(vld && (mCsrRe || mErtn)));
        checkOutput("csr_we", 64'(csr_we), 64'(expCommit && mCsrWe && !expEx));
        checkOutput("csr_num", 64'(csr_num), 64'(mErtn ? 14'h6 : mCsrNum));
        checkOutput("csr_wmask", 64'(csr_wmask), 64'(mMask));
        checkOutput("csr_wvalue", 64'(csr_wvalue), 64'(mWval));
        checkOutput("rf_bus", 64'(rf_bus), 64'({vld, rfWe, mDest, wdata}));
        checkOutput("dbg_rf_we", 64'(debug_wb_rf_we), 64'({4{rfWe}}));
        checkOutput("dbg_wdata", 64'(debug_wb_rf_wdata), 64'(wdata));
        checkOutput("dbg_pc", 64'(debug_wb_pc), 64'(mPc));
        checkOutput("wb_pc", 64'(wb_pc), 64'(mPc));
        checkOutput("esubcode", 64'(wb_esubcode), 64'h0);
        checkOutput("retire_cnt", 64'(retire_cnt), 64'(mCnt));
        if (expEx) begin
            checkOutput("wb_ecode", 64'(wb_ecode), 64'(ecode));
            checkOutput("wb_vaddr", 64'(wb_vaddr), 64'(vaddr));
        end
    endtask

    // Move the model and the DUT across one rising edge, then return at
    // the next falling edge, which is where the following inputs are driven.
    task automatic advanceClock();
        logic take;
        take = ms_to_ws_valid && expAllowin;
        @(posedge clk);
        if (reset) begin
            mValid = 0; mCnt = 0; mPc = 0; mResult = 0; mBadv = 0; mGrWe = 0;
            mDest = 0; mExc = 0; mErtn = 0; mCsrRe = 0; mCsrWe = 0;
            mCsrNum = 0; mMask = 0; mWval = 0;
        end else begin
            if (expCommit && !expEx) mCnt = mCnt + 1;
            if (take) begin
                mPc = ms_pc; mResult = ms_result; mBadv = ms_badv;
                mGrWe = ms_gr_we; mDest = ms_dest; mExc = ms_exc_vec;
                mErtn = ms_ertn; mCsrRe = ms_csr_re; mCsrWe = ms_csr_we;
                mCsrNum = ms_csr_num; mMask = ms_csr_wmask;
                mWval = ms_csr_wvalue;
            end
            if (expEx || expErtn) mValid = 0;
            else if (expAllowin) mValid = ms_to_ws_valid;
        end
        @(negedge clk);
    endtask

    // Random traffic with mostly valid instructions. Stalls, exceptions,
    // interrupts, ERTNs and resets are sprinkled in.
    task automatic randomInputs();
        reset          = ($urandom_range(0, 49) == 0);
        ms_to_ws_valid = ($urandom_range(0, 9) < 7);
        csr_busy       = ($urandom_range(0, 3) == 0);
        int_pending    = ($urandom_range(0, 19) == 0);
        ms_exc_vec     = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'h0;
        ms_ertn        = ($urandom_range(0, 9) == 0);
        ms_csr_re      = ($urandom_range(0, 3) == 0);
        ms_csr_we      = ($urandom_range(0, 3) == 0);
        ms_gr_we       = ($urandom_range(0, 3) != 0);
        ms_pc = $urandom; ms_result = $urandom; ms_badv = $urandom;
        ms_dest = 5'($urandom); ms_csr_num = 14'($urandom);
        ms_csr_wmask = $urandom; ms_csr_wvalue = $urandom;
        csr_rvalue = $urandom; csr_eentry = $urandom; csr_era = $urandom;
    endtask

    // Directed scenarios followed by a randomized run.
    initial begin
        logic [31:0] savedCnt;
        mValid = 0; mCnt = 0; mPc = 0; mResult = 0; mBadv = 0; mGrWe = 0;
        mDest = 0; mExc = 0; mErtn = 0; mCsrRe = 0; mCsrWe = 0;
        mCsrNum = 0; mMask = 0; mWval = 0;
        expAllowin = 1; expCommit = 0; expEx = 0; expErtn = 0;
        idleInputs();
        csr_rvalue = 32'hC5C5_0001; csr_eentry = 32'h1C00_8000;
        csr_era = 32'h1C00_0100;
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(); advanceClock();
        applyStimulus(); advanceClock();
        reset = 1'b0;
        applyStimulus();
        checkOutput("reset_valid", 64'(rf_bus[38]), 64'h0);
        checkOutput("reset_cnt", 64'(retire_cnt), 64'h0);
        advanceClock();

        // A plain ALU instruction commits once and retires.
        $display("[TB] simple commit");
        offerInstr(32'h1C00_0000, 5'd5, 32'h1234);
        applyStimulus(); advanceClock();
        idleInputs();
        applyStimulus();
        checkOutput("c1_rf_we", 64'(rf_bus[37]), 64'h1);
        checkOutput("c1_waddr", 64'(rf_bus[36:32]), 64'h5);
        checkOutput("c1_wdata", 64'(rf_bus[31:0]), 64'h1234);
        checkOutput("c1_cnt0", 64'(retire_cnt), 64'h0);
        advanceClock();
        applyStimulus();
        checkOutput("c1_rf_we_off", 64'(rf_bus[37]), 64'h0);
        checkOutput("c1_cnt1", 64'(retire_cnt), 64'h1);
        advanceClock();

        // SYS and ALE are raised together. SYS has the higher priority. The
        // instruction offered during the flush cycle must be dropped.
        $display("[TB] exception priority");
        offerInstr(32'h1C00_0040, 5'd7, 32'hAAAA);
        ms_exc_vec = 5'b10100; ms_badv = 32'h0000_0BAD;
        applyStimulus(); advanceClock();
        offerInstr(32'h1C00_0044, 5'd8, 32'hBBBB);
        applyStimulus();
        checkOutput("e1_wb_ex", 64'(wb_ex), 64'h1);
        checkOutput("e1_ecode", 64'(wb_ecode), 64'hB);
        checkOutput("e1_rf_we", 64'(rf_bus[37]), 64'h0);
        checkOutput("e1_flush", 64'(flush_pc), 64'h1C00_8000);
        advanceClock();
        idleInputs();
        applyStimulus();
        checkOutput("e1_valid_next", 64'(rf_bus[38]), 64'h0);
        advanceClock();

        // An interrupt preempts an ERTN and does not retire it.
        $display("[TB] interrupt over ertn");
        offerInstr(32'h1C00_0080, 5'd0, 32'h0);
        ms_gr_we = 1'b0; ms_ertn = 1'b1;
        applyStimulus(); advanceClock();
        idleInputs(); int_pending = 1'b1;
        savedCnt = retire_cnt;
        applyStimulus();
        checkOutput("i1_wb_ex", 64'(wb_ex), 64'h1);
        checkOutput("i1_ecode", 64'(wb_ecode), 64'h0);
        checkOutput("i1_ertn", 64'(wb_ertn), 64'h0);
        advanceClock();
        int_pending = 1'b0;
        applyStimulus();
        checkOutput("i1_cnt_same", 64'(retire_cnt), 64'(savedCnt));
        advanceClock();

        // A csrwr waits three cycles behind a busy CSR file and then writes
        // exactly once.
        $display("[TB] csr stall");
        offerInstr(32'h1C00_00C0, 5'd0, 32'h0);
        ms_gr_we = 1'b0; ms_csr_we = 1'b1; ms_csr_num = 14'h0C;
        ms_csr_wmask = 32'hFFFF_FFFF; ms_csr_wvalue = 32'h1C00_4000;
        applyStimulus(); advanceClock();
        idleInputs();
        for (int k = 0; k < 3; k++) begin
            csr_busy = 1'b1;
            applyStimulus();
            checkOutput("s1_allowin", 64'(ws_allowin), 64'h0);
            checkOutput("s1_csr_we_hold", 64'(csr_we), 64'h0);
            advanceClock();
        end
        csr_busy = 1'b0;
        applyStimulus();
        checkOutput("s1_csr_we", 64'(csr_we), 64'h1);
        checkOutput("s1_csr_num", 64'(csr_num), 64'h0C);
        advanceClock();
        applyStimulus();
        checkOutput("s1_csr_we_once", 64'(csr_we), 64'h0);
        advanceClock();

        // The retire counter wraps from all-ones to zero.
        $display("[TB] counter wrap");
        offerInstr(32'h1C00_0100, 5'd3, 32'h33);
        applyStimulus(); advanceClock();
        idleInputs();
        force dut.retireCnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retireCnt_q;
        mCnt = 32'hFFFF_FFFF;
        applyStimulus(); advanceClock();
        applyStimulus();
        checkOutput("w1_wrap", 64'(retire_cnt), 64'h0);
        advanceClock();

        // A reset during a stall cancels the pending CSR write.
        $display("[TB] reset mid-stall");
        offerInstr(32'h1C00_0140, 5'd0, 32'h0);
        ms_gr_we = 1'b0; ms_csr_we = 1'b1; ms_csr_num = 14'h0C;
        applyStimulus(); advanceClock();
        idleInputs(); csr_busy = 1'b1;
        applyStimulus(); advanceClock();
        reset = 1'b1;
        applyStimulus();
        checkOutput("r1_csr_we", 64'(csr_we), 64'h0);
        checkOutput("r1_valid", 64'(rf_bus[38]), 64'h0);
        advanceClock();
        reset = 1'b0; csr_busy = 1'b0;
        applyStimulus();
        checkOutput("r1_valid_after", 64'(rf_bus[38]), 64'h0);
        checkOutput("r1_csr_we_after", 64'(csr_we), 64'h0);
        advanceClock();

        // Randomized traffic against the model.
        $display("[TB] random run");
        for (int n = 0; n < 400; n++) begin
            randomInputs();
            applyStimulus();
            advanceClock();
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/wb_commit_stage.md
WB_COMMIT_STAGE -- requirements
Module: wb_commit_stage

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of data, PC, CSR value/mask and bad-address paths.
REQ-002 Parameter NUM_EXC, default 5, SHALL set the number of synchronous exception sources; bit 0 has the highest priority.
REQ-003 Parameter ECODE_TABLE, default {6'h9,6'hC,6'hB,6'hD,6'h8}, SHALL hold NUM_EXC 6-bit ecodes; entry i sits at bits [6i+5:6i], so bit 0 maps to 8 (ADEF) and bit 4 maps to 9 (ALE).
REQ-004 Parameter CNT_W, default 32, SHALL set the retired-instruction counter width.
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 ms_to_ws_valid  in  1  upstream instruction valid.
REQ-008 ws_allowin  out  1  stage can accept an instruction this cycle.
REQ-009 ms_pc / ms_result / ms_badv  in  DATA_W each  instruction PC, ALU/load result, faulting data address.
REQ-010 ms_gr_we  in  1 and ms_dest  in  5  GPR write enable and destination.
REQ-011 ms_exc_vec  in  NUM_EXC  synchronous exception flags.
REQ-012 ms_ertn, ms_csr_re, ms_csr_we  in  1 each; ms_csr_num  in  14; ms_csr_wmask and ms_csr_wvalue  in  DATA_W each.
REQ-013 int_pending  in  1  qualified interrupt request from the CSR file.
REQ-014 csr_busy  in  1  CSR file not ready; the stage SHALL stall while it is high.
REQ-015 csr_rvalue / csr_eentry / csr_era  in  DATA_W each  CSR read data, exception entry, return address.
REQ-016 csr_re, csr_we  out  1 each; csr_num  out  14; csr_wmask, csr_wvalue  out  DATA_W each.
REQ-017 wb_ex, wb_ertn  out  1 each; wb_ecode  out  6; wb_esubcode  out  9; wb_pc, wb_vaddr  out  DATA_W each.
REQ-018 flush_pc  out  DATA_W  redirect target.
REQ-019 rf_bus  out  DATA_W+7  {ws_valid, rf_we, rf_waddr[4:0], rf_wdata}, used for forwarding and the register-file write.
REQ-020 retire_cnt  out  CNT_W  count of committed instructions.
REQ-021 debug_wb_pc  out  DATA_W; debug_wb_rf_we  out  4; debug_wb_rf_wnum  out  5; debug_wb_rf_wdata  out  DATA_W.

Function
REQ-022 All ms_* fields SHALL be captured into one register set when ms_to_ws_valid && ws_allowin, and SHALL otherwise hold.
REQ-023 ws_valid SHALL load ms_to_ws_valid when ws_allowin is high; ws_ready_go = !csr_busy; ws_allowin = !ws_valid || ws_ready_go.
REQ-024 commit = ws_valid && ws_ready_go; every output side effect SHALL be gated by commit.
REQ-025 Exception priority SHALL be: int_pending first (ecode 0), then the lowest set index of ms_exc_vec (ecode from ECODE_TABLE); wb_ecode SHALL be 0 when no exception is pending.
REQ-026 wb_ex = commit && (int_pending || |exc_vec); wb_ertn = commit && ertn && !wb_ex.
REQ-027 wb_vaddr SHALL equal pc when the selected source is bit 0 (ADEF), badv when the selected source is bit NUM_EXC-1 (ALE), and 0 otherwise; wb_esubcode SHALL be 0.
REQ-028 flush_pc SHALL be csr_eentry when wb_ex, csr_era when wb_ertn, and 0 otherwise.
REQ-029 csr_num SHALL be 14'h6 (ERA) when ertn, and the captured csr_num otherwise.
REQ-030 csr_re = ws_valid && (csr_re_r || ertn), and SHALL be held during a stall.
REQ-031 csr_we = commit && csr_we_r && !wb_ex; the CSR file SHALL therefore see exactly one write-enable cycle per instruction.
REQ-032 rf_we = commit && gr_we && !wb_ex; rf_wdata = csr_rvalue when csr_re_r, else result.
REQ-033 The debug outputs SHALL mirror rf_bus: debug_wb_rf_we = {4{rf_we}} and debug_wb_pc = pc.
REQ-034 On wb_ex or wb_ertn, ws_valid SHALL clear next cycle, and the ms_to_ws_valid offered in that cycle SHALL be discarded.
REQ-035 retire_cnt SHALL increment by 1 on each commit without wb_ex (ertn counts), and SHALL wrap from all-ones to 0.

Reset
REQ-036 When reset is high at a clock edge, ws_valid and retire_cnt SHALL clear to 0, and every registered payload SHALL clear to 0.
REQ-037 During reset, wb_ex, wb_ertn, csr_we, csr_re, rf_we and the rf_bus valid bit SHALL be 0; reset SHALL override a concurrent flush or capture.

Verification
REQ-038 Valid instruction (pc=0x1C000000, gr_we=1, dest=5, result=0x1234), csr_busy=0 -> rf_we=1 for exactly one cycle with waddr 5 / wdata 0x1234, and retire_cnt 0->1.
REQ-039 exc_vec=5'b10100 with int_pending=0 -> wb_ex=1, wb_ecode=0xB (SYS wins over ALE), rf_we=0, flush_pc=csr_eentry, ws_valid=0 next cycle.
REQ-040 int_pending=1 with an ertn instruction -> wb_ex=1, wb_ecode=0, wb_ertn=0, and retire_cnt unchanged.
REQ-041 csrwr num 0x0C with csr_busy=1 for 3 cycles -> ws_allowin=0 and csr_we=0 for 3 cycles, then csr_we=1 for exactly 1 cycle.
REQ-042 retire_cnt preloaded to 0xFFFFFFFF by forcing, then one commit -> retire_cnt=0; reset asserted mid-stall -> ws_valid=0 and no write issued.
